// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified instruction/data RAM arbiter.
//   arb_state_e : sequencer states (IDLE, RD, WR, DONE)
//   owner_e     : which requester currently owns the RAM port
//   RD_LAT_MAX  : largest supported RAM read latency
//   CNT_W       : width of the read-latency countdown
//   lat_load()  : turns the RD_LAT parameter into a legal countdown preset
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    localparam int RD_LAT_MAX = 3;
    localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

    // Clamp the requested read latency into 1..RD_LAT_MAX so an out-of-range
    // build parameter can never produce a zero-length or overflowing countdown.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        int clamped;
        if (lat < 1) begin
            clamped = 1;
        end else if (lat > RD_LAT_MAX) begin
            clamped = RD_LAT_MAX;
        end else begin
            clamped = lat;
        end
        return CNT_W'(clamped);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates the single-port unified RAM between the fetch stage (IF) and the
// memory stage (MEM), sequences the RAM read latency and the store write
// enable, and stalls the pipeline while an accepted request is outstanding.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req / if_addr           fetch read request (level, held until if_valid)
//   if_rdata / if_valid        fetched word and its one-cycle valid pulse
//   mem_req / mem_w_en         memory-stage request, 1 = store, 0 = load
//   mem_addr / mem_wdata       data word address and store data
//   mem_rdata / mem_done       load data and one-cycle completion pulse
//   sel_stall                  pipeline stall (combinational)
//   ram_addr/ram_wren/ram_wdata/ram_rdata   RAM macro interface
//
// Timing (cycle 0 = the IDLE cycle in which the request is sampled)
//   load/fetch : RD for RD_LAT+1 cycles, pulse in cycle RD_LAT+2
//   store      : single WR cycle, ram_wren and mem_done in cycle 1
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              mem_req,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              sel_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_e          state_r;
    owner_e              owner_r;
    owner_e              last_owner_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [ADDR_W-1:0]   ram_addr_r;
    logic [31:0]         ram_wdata_r;
    logic [31:0]         if_rdata_r;
    logic [31:0]         mem_rdata_r;

    logic                grant_any_s;
    logic                grant_mem_s;
    logic                grant_store_s;
    logic [ADDR_W-1:0]   grant_addr_s;

    // Grant decision for the IDLE cycle; on contention the requester that
    // did not own the port last time wins, so the two sides alternate.
    always_comb begin
        grant_any_s = if_req | mem_req;
        if (mem_req && if_req) begin
            grant_mem_s = (last_owner_r == OWN_IF);
        end else if (mem_req) begin
            grant_mem_s = 1'b1;
        end else begin
            grant_mem_s = 1'b0;
        end
        if (grant_mem_s) begin
            grant_addr_s  = mem_addr;
            grant_store_s = mem_w_en;
        end else begin
            grant_addr_s  = if_addr;
            grant_store_s = 1'b0;
        end
    end

    // Sequencer: grant, read countdown / single-cycle write, completion.
    // Address and store data are captured only at grant, so requester-side
    // changes while busy never reach the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            owner_r      <= OWN_IF;
            last_owner_r <= OWN_MEM;
            cnt_r        <= {CNT_W{1'b0}};
            ram_addr_r   <= {ADDR_W{1'b0}};
            ram_wdata_r  <= 32'h0000_0000;
            if_rdata_r   <= 32'h0000_0000;
            mem_rdata_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        owner_r    <= grant_mem_s ? OWN_MEM : OWN_IF;
                        ram_addr_r <= grant_addr_s;
                        if (grant_store_s) begin
                            ram_wdata_r <= mem_wdata;
                            state_r     <= WR;
                        end else begin
                            cnt_r   <= LAT_LOAD;
                            state_r <= RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    // RAM data is valid once the countdown has expired.
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (owner_r == OWN_MEM) begin
                            mem_rdata_r <= ram_rdata;
                        end else begin
                            if_rdata_r <= ram_rdata;
                        end
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                WR: begin
                    last_owner_r <= OWN_MEM;
                    state_r      <= IDLE;
                end
                DONE: begin
                    last_owner_r <= owner_r;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Pulses and write enable decode straight from registered state so they
    // are glitch-free and vanish the moment rst_n asserts.
    assign ram_wren  = (state_r == WR);
    assign if_valid  = (state_r == DONE) && (owner_r == OWN_IF);
    assign mem_done  = (state_r == WR) || ((state_r == DONE) && (owner_r == OWN_MEM));

    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign mem_rdata = mem_rdata_r;

    // Stall while either requester still waits for its completion pulse.
    assign sel_stall = (if_req & ~if_valid) | (mem_req & ~mem_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Two instances share one RAM image:
// dut1 built with RD_LAT=1 (full feature set) and dut3 with RD_LAT=3
// (latency and address-latching). Inputs change on the falling edge and
// outputs are sampled on the falling edge; "cycle 0" is the cycle in which
// the request is first presented.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // dut1 (RD_LAT = 1)
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              mem_req;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              sel_stall;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // dut3 (RD_LAT = 3)
    logic              if3_req;
    logic [ADDR_W-1:0] if3_addr;
    logic [31:0]       if3_rdata;
    logic              if3_valid;
    logic              mem3_req;
    logic              mem3_w_en;
    logic [ADDR_W-1:0] mem3_addr;
    logic [31:0]       mem3_wdata;
    logic [31:0]       mem3_rdata;
    logic              mem3_done;
    logic              sel3_stall;
    logic [ADDR_W-1:0] ram3_addr;
    logic              ram3_wren;
    logic [31:0]       ram3_wdata;
    logic [31:0]       ram3_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req(mem_req), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .sel_stall(sel_stall), .ram_addr(ram_addr), .ram_wren(ram_wren),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if3_req), .if_addr(if3_addr), .if_rdata(if3_rdata), .if_valid(if3_valid),
        .mem_req(mem3_req), .mem_w_en(mem3_w_en), .mem_addr(mem3_addr),
        .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata), .mem_done(mem3_done),
        .sel_stall(sel3_stall), .ram_addr(ram3_addr), .ram_wren(ram3_wren),
        .ram_wdata(ram3_wdata), .ram_rdata(ram3_rdata)
    );

    // RAM model: dut1 writes it, both read it; read data appears 1 cycle
    // (dut1) or 3 cycles (dut3) after the address. A preload port fills it.
    logic [31:0]       ram [0:2047];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [31:0]       pre_data;
    logic [31:0]       rd1_q, rd3_p1, rd3_p2, rd3_p3;

    always @(posedge clk) begin
        if (ram_wren) ram[ram_addr] <= ram_wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
        rd1_q  <= ram[ram_addr];
        rd3_p1 <= ram[ram3_addr];
        rd3_p2 <= rd3_p1;
        rd3_p3 <= rd3_p2;
    end
    assign ram_rdata  = rd1_q;
    assign ram3_rdata = rd3_p3;

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_w_en = 1'b0; if3_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({if_valid, mem_done, ram_wren, sel_stall} !== 4'b0000) $display("FAIL reset_pulses: got %b expected 0000", {if_valid, mem_done, ram_wren, sel_stall});
        else pass_cnt++;
        total_cnt++;
        if (ram_addr !== 11'h000) $display("FAIL reset_ram_addr: got %h expected 000", ram_addr);
        else pass_cnt++;
        total_cnt++;
        if ({ram_wdata, if_rdata, mem_rdata} !== 96'h0) $display("FAIL reset_data: got %h expected 0", {ram_wdata, if_rdata, mem_rdata});
        else pass_cnt++;
        total_cnt++;
        if ({if3_valid, mem3_done, ram3_wren, ram3_addr} !== 14'h0) $display("FAIL reset_dut3: got %h expected 0", {if3_valid, mem3_done, ram3_wren, ram3_addr});
        else pass_cnt++;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        if_req = 1'b1; if_addr = 11'h004;
        #1;
        total_cnt++;
        if (sel_stall !== 1'b1) $display("FAIL fetch_stall_c0: got %b expected 1", sel_stall);
        else pass_cnt++;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if (if_valid !== (c == 3)) $display("FAIL fetch_valid_c%0d: got %b expected %b", c, if_valid, (c == 3));
            else pass_cnt++;
            total_cnt++;
            if (sel_stall !== (c != 3)) $display("FAIL fetch_stall_c%0d: got %b expected %b", c, sel_stall, (c != 3));
            else pass_cnt++;
            total_cnt++;
            if (ram_wren !== 1'b0) $display("FAIL fetch_wren_c%0d: got %b expected 0", c, ram_wren);
            else pass_cnt++;
            if (c == 1) begin
                total_cnt++;
                if (ram_addr !== 11'h004) $display("FAIL fetch_ram_addr: got %h expected 004", ram_addr);
                else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++;
                if (if_rdata !== 32'hE3A01005) $display("FAIL fetch_rdata: got %h expected e3a01005", if_rdata);
                else pass_cnt++;
                if_req = 1'b0;
            end
        end
        @(negedge clk);
        total_cnt++;
        if (if_valid !== 1'b0) $display("FAIL fetch_single_pulse: got %b expected 0", if_valid);
        else pass_cnt++;
    endtask

    task automatic test_store();
        @(negedge clk);
        mem_req = 1'b1; mem_w_en = 1'b1; mem_addr = 11'h010; mem_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total_cnt++;
        if ({ram_wren, mem_done} !== 2'b11) $display("FAIL store_wren_done: got %b expected 11", {ram_wren, mem_done});
        else pass_cnt++;
        total_cnt++;
        if (ram_addr !== 11'h010) $display("FAIL store_ram_addr: got %h expected 010", ram_addr);
        else pass_cnt++;
        total_cnt++;
        if (ram_wdata !== 32'hDEADBEEF) $display("FAIL store_ram_wdata: got %h expected deadbeef", ram_wdata);
        else pass_cnt++;
        mem_req = 1'b0; mem_w_en = 1'b0; mem_wdata = 32'h0000_0000;
        @(negedge clk);
        total_cnt++;
        if ({ram_wren, mem_done} !== 2'b00) $display("FAIL store_one_cycle: got %b expected 00", {ram_wren, mem_done});
        else pass_cnt++;
        // load back the stored word
        mem_req = 1'b1; mem_addr = 11'h010;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if (mem_done !== (c == 3)) $display("FAIL load_done_c%0d: got %b expected %b", c, mem_done, (c == 3));
            else pass_cnt++;
        end
        total_cnt++;
        if (mem_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h expected deadbeef", mem_rdata);
        else pass_cnt++;
        mem_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        if_req = 1'b1; if_addr = 11'h008;
        mem_req = 1'b1; mem_w_en = 1'b0; mem_addr = 11'h020;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            total_cnt++;
            if (if_valid !== (c == 3)) $display("FAIL sim_if_valid_c%0d: got %b expected %b", c, if_valid, (c == 3));
            else pass_cnt++;
            total_cnt++;
            if (mem_done !== (c == 7)) $display("FAIL sim_mem_done_c%0d: got %b expected %b", c, mem_done, (c == 7));
            else pass_cnt++;
            total_cnt++;
            if (sel_stall !== (c != 7)) $display("FAIL sim_stall_c%0d: got %b expected %b", c, sel_stall, (c != 7));
            else pass_cnt++;
            if (c == 3) begin
                total_cnt++;
                if (if_rdata !== 32'hE5901000) $display("FAIL sim_if_rdata: got %h expected e5901000", if_rdata);
                else pass_cnt++;
                if_req = 1'b0;
            end
            if (c == 5) begin
                total_cnt++;
                if (ram_addr !== 11'h020) $display("FAIL sim_mem_addr: got %h expected 020", ram_addr);
                else pass_cnt++;
            end
            if (c == 7) begin
                total_cnt++;
                if (mem_rdata !== 32'hCAFEF00D) $display("FAIL sim_mem_rdata: got %h expected cafef00d", mem_rdata);
                else pass_cnt++;
                mem_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic seen;
        // reset while MEM load is in RD
        @(negedge clk);
        mem_req = 1'b1; mem_w_en = 1'b0; mem_addr = 11'h020;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({ram_wren, mem_done, if_valid} !== 3'b000) $display("FAIL abort_rd_outputs: got %b expected 000", {ram_wren, mem_done, if_valid});
        else pass_cnt++;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (if_valid || mem_done) seen = 1'b1;
        end
        mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // reset during the write cycle
        @(negedge clk);
        mem_req = 1'b1; mem_w_en = 1'b1; mem_addr = 11'h030; mem_wdata = 32'h1111_2222;
        @(negedge clk);
        total_cnt++;
        if (ram_wren !== 1'b1) $display("FAIL abort_wr_pre: got %b expected 1", ram_wren);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({ram_wren, mem_done} !== 2'b00) $display("FAIL abort_wr_async: got %b expected 00", {ram_wren, mem_done});
        else pass_cnt++;
        mem_req = 1'b0; mem_w_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (if_valid || mem_done || ram_wren) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (if_valid || mem_done || ram_wren) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_no_pulse: got %b expected 0", seen);
        else pass_cnt++;
        // last_owner must be MEM after reset: IF wins contention
        if_req = 1'b1; if_addr = 11'h004;
        mem_req = 1'b1; mem_addr = 11'h000;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({if_valid, mem_done} !== 2'b10) $display("FAIL abort_last_owner: got %b expected 10", {if_valid, mem_done});
        else pass_cnt++;
        if_req = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++;
        if ({mem_done, mem_rdata} !== {1'b1, 32'h12345678}) $display("FAIL abort_mem_after: got %h expected 112345678", {mem_done, mem_rdata});
        else pass_cnt++;
        mem_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int idx;
        int cyc;
        logic exp_mem;
        apply_reset();
        if_req = 1'b1; if_addr = 11'h008;
        mem_req = 1'b1; mem_w_en = 1'b0; mem_addr = 11'h020;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (if_valid || mem_done) begin
                exp_mem = (idx % 2) == 1;
                total_cnt++;
                if ({if_valid, mem_done} !== {~exp_mem, exp_mem}) $display("FAIL b2b_owner_%0d: got %b expected %b", idx, {if_valid, mem_done}, {~exp_mem, exp_mem});
                else pass_cnt++;
                total_cnt++;
                if (exp_mem ? (mem_rdata !== 32'hCAFEF00D) : (if_rdata !== 32'hE5901000))
                    $display("FAIL b2b_data_%0d: got if=%h mem=%h expected %h", idx, if_rdata, mem_rdata, exp_mem ? 32'hCAFEF00D : 32'hE5901000);
                else pass_cnt++;
                idx++;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        total_cnt++;
        if (idx !== 8) $display("FAIL b2b_count: got %0d expected 8 within 60 cycles", idx);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rd_lat3();
        @(negedge clk);
        if3_req = 1'b1; if3_addr = 11'h000;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total_cnt++;
            if (ram3_addr !== 11'h000) $display("FAIL lat3_ram_addr_c%0d: got %h expected 000", c, ram3_addr);
            else pass_cnt++;
            total_cnt++;
            if (if3_valid !== (c == 5)) $display("FAIL lat3_valid_c%0d: got %b expected %b", c, if3_valid, (c == 5));
            else pass_cnt++;
            total_cnt++;
            if ({ram3_wren, mem3_done} !== 2'b00) $display("FAIL lat3_wren_c%0d: got %b expected 00", c, {ram3_wren, mem3_done});
            else pass_cnt++;
            if (c == 1) if3_addr = 11'h7FF;
            if (c == 5) begin
                total_cnt++;
                if (if3_rdata !== 32'h12345678) $display("FAIL lat3_rdata: got %h expected 12345678", if3_rdata);
                else pass_cnt++;
                total_cnt++;
                if (sel3_stall !== 1'b0) $display("FAIL lat3_stall: got %b expected 0", sel3_stall);
                else pass_cnt++;
                if3_req = 1'b0;
            end
        end
        total_cnt++;
        if ({mem3_rdata, ram3_wdata} !== 64'h0) $display("FAIL lat3_untouched: got %h expected 0", {mem3_rdata, ram3_wdata});
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 11'h000;
        mem_req = 1'b0; mem_w_en = 1'b0; mem_addr = 11'h000; mem_wdata = 32'h0;
        if3_req = 1'b0; if3_addr = 11'h000;
        mem3_req = 1'b0; mem3_w_en = 1'b0; mem3_addr = 11'h000; mem3_wdata = 32'h0;
        pre_we = 1'b0; pre_addr = 11'h000; pre_data = 32'h0;

        preload(11'h000, 32'h12345678);
        preload(11'h004, 32'hE3A01005);
        preload(11'h008, 32'hE5901000);
        preload(11'h020, 32'hCAFEF00D);
        preload(11'h7FF, 32'h0BADC0DE);

        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_fetch();
        test_store();
        test_simultaneous();
        test_reset_abort();
        test_back_to_back();
        test_rd_lat3();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
